// File: rtl/gost34_12_2015_magma_core_if.sv
// Request/response bundle for the Magma block cipher core.
// The master issues blocks and accepts results; the slave is the core.
interface gost34_12_2015_magma_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_decrypt;
    logic [63:0]  in_data;
    logic [255:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    modport master (
        output in_valid,
        output in_decrypt,
        output in_data,
        output key,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_decrypt,
        input  in_data,
        input  key,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/gost34_12_2015_magma_core.sv
// Iterative GOST 34.12-2015 "Magma" 64-bit block cipher, one round per clock.
// Define GOST_MAGMA_SBOX_REG_EN to register the S-layer (two clocks per round).
module gost34_12_2015_magma_core #(
    parameter int ROUNDS = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [511:0]                    sbox,
    gost34_12_2015_magma_core_if.slave      bus
);

    localparam int RW = $clog2(ROUNDS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           accept;

    logic [31:0]    a1;
    logic [31:0]    a0;
    logic [255:0]   kreg;
    logic           dec;
    logic [RW-1:0]  rnd;
    logic [63:0]    dout;

    logic           last;
    logic           step;
    logic           fwd;
    logic [2:0]     kidx;
    logic [31:0]    ksel;
    logic [31:0]    sum;
    logic [31:0]    sub;
    logic [31:0]    gin;
    logic [31:0]    g;

    // Forward key order for the leading rounds, reversed for the tail.
    assign fwd  = dec ? (rnd < RW'(8)) : (rnd < RW'(ROUNDS - 8));
    assign kidx = fwd ? rnd[2:0] : ~rnd[2:0];
    assign ksel = kreg[{~kidx, 5'd0} +: 32];
    assign sum  = a0 + ksel;

    // Entry v of pi_i sits at nibble (15-v) of table word i.
    for (genvar i = 0; i < 8; i++) begin : g_slayer
        logic [3:0] nib;
        assign nib = sum[4*i +: 4];
        assign sub[4*i +: 4] = sbox[{3'(i), ~nib, 2'b00} +: 4];
    end

    assign g    = {gin[20:0], gin[31:21]};
    assign last = (rnd == RW'(ROUNDS - 1));

`ifdef GOST_MAGMA_SBOX_REG_EN
    logic           phase;
    logic [31:0]    sreg;

    assign step = (state == RUN) && phase;
    assign gin  = sreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
            sreg  <= '0;
        end else if (accept) begin
            phase <= 1'b0;
        end else if (state == RUN) begin
            if (!phase) begin
                sreg <= sub;
            end
            phase <= ~phase;
        end
    end
`else
    assign step = (state == RUN);
    assign gin  = sub;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (step && last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a1   <= '0;
            a0   <= '0;
            kreg <= '0;
            dec  <= 1'b0;
            rnd  <= '0;
            dout <= '0;
        end else if (accept) begin
            a1   <= bus.in_data[63:32];
            a0   <= bus.in_data[31:0];
            kreg <= bus.key;
            dec  <= bus.in_decrypt;
            rnd  <= '0;
        end else if (step) begin
            if (last) begin
                // Final round leaves the halves unswapped.
                dout <= {g ^ a1, a0};
            end else begin
                a1  <= a0;
                a0  <= g ^ a1;
                rnd <= rnd + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = dout;

endmodule

// File: tb/tb_gost34_12_2015_magma_core.sv
// Self-checking bench for the Magma core: RFC 8891 vectors, flow control,
// reset abort, streaming and a randomized comparison against a reference model.
module tb_gost34_12_2015_magma_core;

    localparam int ROUNDS = 32;
`ifdef GOST_MAGMA_SBOX_REG_EN
    localparam int LAT = 2 * ROUNDS;
`else
    localparam int LAT = ROUNDS;
`endif

    localparam logic [511:0] STD = {
        64'h17ED05834FA69CB2, 64'h8E25691CF4B0DA37,
        64'h5DF692CAB78143E0, 64'h7F5A816D093EB42C,
        64'hC821D4F670A53E9B, 64'hB3582FADE174C960,
        64'h68239A5C1E47BD0F, 64'hC462A5B9E8D703F1
    };
    localparam logic [511:0] IDT = {8{64'h0123456789ABCDEF}};
    localparam logic [255:0] RK =
        256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0] PT = 64'hfedcba9876543210;
    localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] sbox;
    longint       cyc = 0;
    int           checks = 0;
    int           errors = 0;

    gost34_12_2015_magma_core_if bus();

    gost34_12_2015_magma_core #(.ROUNDS(ROUNDS)) dut (
        .clk  (clk),
        .rst  (rst),
        .sbox (sbox),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model straight from the cipher definition.
    function automatic logic [63:0] model(input logic [63:0] d,
                                          input logic [255:0] k,
                                          input logic [511:0] sb,
                                          input bit dc);
        logic [3:0]  pi [8][16];
        logic [31:0] kw [8];
        logic [31:0] x1, x0, s, y, g, t;
        int          ki, lim;
        for (int i = 0; i < 8; i++)
            for (int v = 0; v < 16; v++)
                pi[i][v] = sb[64*i + 4*(15-v) +: 4];
        for (int j = 0; j < 8; j++)
            kw[j] = k[255 - 32*j -: 32];
        x1  = d[63:32];
        x0  = d[31:0];
        lim = dc ? 8 : ROUNDS - 8;
        for (int r = 0; r < ROUNDS; r++) begin
            ki = (r < lim) ? (r % 8) : (7 - (r % 8));
            s  = x0 + kw[ki];
            for (int i = 0; i < 8; i++)
                y[4*i +: 4] = pi[i][s[4*i +: 4]];
            g = (y << 11) | (y >> 21);
            t = g ^ x1;
            if (r == ROUNDS - 1) return {t, x0};
            x1 = x0;
            x0 = t;
        end
        return '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [63:0] d;
        longint      t;
        bit          seen;
    } exp_t;
    exp_t q[$];

    // Scoreboard: every accepted block must come back once, in order, on time.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    if (!q[0].seen) begin
                        q[0].seen = 1'b1;
                        chk("latency", 64'(cyc - q[0].t), 64'(LAT));
                    end
                    chk("sb_data", bus.out_data, q[0].d);
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back('{model(bus.in_data, bus.key, sbox,
                                    bus.in_decrypt), cyc + 1, 1'b0});
        end
    end

    task automatic send(input logic [63:0] d, input logic dc,
                        input logic [255:0] k);
        bit ok;
        ok = 1'b0;
        bus.in_data    = d;
        bus.in_decrypt = dc;
        bus.key        = k;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic get(input logic [63:0] exp, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
        else chk(name, bus.out_data, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint      tm [4];
        logic [63:0] od [4];
        logic [63:0] hold;
        logic [63:0] d;
        logic [255:0] k;
        bit          dc;
        int          n, cnt;

        rst            = 1'b1;
        sbox           = STD;
        bus.in_valid   = 1'b0;
        bus.in_decrypt = 1'b0;
        bus.in_data    = '0;
        bus.key        = '0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        chk("model_rfc_enc", model(PT, RK, STD, 1'b0), CT);
        chk("model_rfc_dec", model(CT, RK, STD, 1'b1), PT);
        chk("model_ident", model(64'd0, 256'd0, IDT, 1'b0), 64'd0);

        send(PT, 1'b0, RK);
        get(CT, "rfc_enc");
        send(CT, 1'b1, RK);
        get(PT, "rfc_dec");

        // Back-pressure with stray requests in RUN and DONE.
        bus.out_ready = 1'b0;
        send(PT, 1'b0, RK);
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0123456789abcdef;
        @(negedge clk);
        chk("bp_ready_run", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n = 1;
                break;
            end
        end
        if (n == 0) chk("bp_timeout", 64'd0, 64'd1);
        hold = bus.out_data;
        chk("bp_value", hold, CT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_data  = 64'(i) * 64'h1111;
            @(negedge clk);
            chk("bp_hold", bus.out_data, hold);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_ready_done", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        chk("bp_no_second", 64'(cnt), 64'd0);

        // Reset abort partway through the rounds.
        send(PT, 1'b0, RK);
        repeat (LAT / 2 - 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_out_data", bus.out_data, 64'd0);
        @(posedge clk);
        #1;
        send(PT, 1'b0, RK);
        get(CT, "abort_fresh");

        // Back-to-back streaming with out_ready held high.
        n = 0;
        fork
            begin
                send(PT, 1'b0, RK);
                send(64'd0, 1'b0, RK);
                send(PT, 1'b0, RK);
                send(64'd0, 1'b0, RK);
            end
            begin
                for (int i = 0; i < 400 && n < 4; i++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        tm[n] = cyc;
                        od[n] = bus.out_data;
                        n++;
                    end
                end
            end
        join
        chk("stream_count", 64'(n), 64'd4);
        if (n == 4) begin
            for (int i = 0; i < 3; i++)
                chk("stream_gap", 64'(tm[i+1] - tm[i]), 64'(LAT + 2));
            chk("stream_0", od[0], CT);
            chk("stream_1", od[1], model(64'd0, RK, STD, 1'b0));
            chk("stream_2", od[2], CT);
            chk("stream_3", od[3], model(64'd0, RK, STD, 1'b0));
        end
        @(posedge clk);
        #1;

        sbox = IDT;
        send(64'd0, 1'b0, 256'd0);
        get(64'd0, "ident_zero");

        for (int it = 0; it < 1000; it++) begin
            for (int i = 0; i < 16; i++) sbox[32*i +: 32] = $urandom();
            for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
            d  = {$urandom(), $urandom()};
            dc = 1'($urandom_range(0, 1));
            send(d, dc, k);
            get(model(d, k, sbox, dc), "rand");
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
